// File: rtl/aes_pkg.sv
// Shared constants and FSM encoding for the AES-128 key-schedule controller.
package aes_pkg;

  localparam int unsigned NR              = 10;
  localparam int unsigned CNT_LAST        = 7;
  localparam int unsigned KEY_STORE_DEPTH = 11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EXPAND,
    CAPT,
    DONE
  } ks_state_e;

endpackage

// File: rtl/key_schedule_ctrl_if.sv
// Key handshake and round-key read bundle seen by the consumer of key_schedule_ctrl.
interface key_schedule_ctrl_if #(
  parameter int unsigned KW = 128
);

  logic          key_valid;
  logic [KW-1:0] key_in;
  logic          key_ready;
  logic [3:0]    rk_rd_addr;
  logic [KW-1:0] rk_rd_data;
  logic          keys_valid;
  logic          busy;

  modport master (
    output key_valid, key_in, rk_rd_addr,
    input  key_ready, rk_rd_data, keys_valid, busy
  );

  modport slave (
    input  key_valid, key_in, rk_rd_addr,
    output key_ready, rk_rd_data, keys_valid, busy
  );

endinterface

// File: rtl/round_key_store.sv
// Round-key storage: one synchronous write port, one registered read port.
module round_key_store #(
  parameter int unsigned DEPTH = 11,
  parameter int unsigned KW    = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [3:0]    wr_addr_i,
  input  logic [KW-1:0] wr_data_i,
  input  logic [3:0]    rd_addr_i,
  output logic [KW-1:0] rd_data_o
);

  localparam logic [3:0] LAST_IDX = 4'(DEPTH - 1);

  logic [KW-1:0] mem_q [DEPTH];
  logic [KW-1:0] rd_data_q;

  // Contents are not reset; keys_valid masks them for consumers.
  always_ff @(posedge clk) begin
    if (we_i && (wr_addr_i <= LAST_IDX)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_addr_i <= LAST_IDX) begin
      rd_data_q <= mem_q[rd_addr_i];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/key_schedule_ctrl.sv
// AES-128 key-schedule controller: sequences the external key-expansion stage
// through rounds 1..NR and captures each round key into the round-key store.
module key_schedule_ctrl #(
  parameter int unsigned NR = 10,
  parameter int unsigned KW = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          key_valid,
  input  logic [KW-1:0] key_in,
  output logic          key_ready,
  output logic [KW-1:0] ke_key_o,
  output logic [3:0]    ke_round_o,
  output logic [2:0]    ke_cnt_o,
  input  logic [KW-1:0] ke_round_key_i,
  input  logic [3:0]    rk_rd_addr,
  output logic [KW-1:0] rk_rd_data,
  output logic          keys_valid,
  output logic          busy
);

  import aes_pkg::*;

  localparam logic [3:0] ROUND_LAST = 4'(NR);
  localparam logic [2:0] CNT_END    = 3'(CNT_LAST);

  ks_state_e     state_q, state_d;
  logic [3:0]    round_q, round_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [KW-1:0] key_q, key_d;
  logic          keys_valid_q, keys_valid_d;

  logic          st_we;
  logic [3:0]    st_waddr;
  logic [KW-1:0] st_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      round_q      <= '0;
      cnt_q        <= '0;
      key_q        <= '0;
      keys_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      cnt_q        <= cnt_d;
      key_q        <= key_d;
      keys_valid_q <= keys_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    round_d      = round_q;
    cnt_d        = cnt_q;
    key_d        = key_q;
    keys_valid_d = keys_valid_q;
    st_we        = 1'b0;
    st_waddr     = round_q;
    st_wdata     = ke_round_key_i;
    key_ready    = 1'b0;
    busy         = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        key_ready = 1'b1;
        // The cipher key itself is round key 0, stored on the handshake edge.
        if (key_valid) begin
          state_d      = LOAD;
          key_d        = key_in;
          round_d      = '0;
          cnt_d        = '0;
          keys_valid_d = 1'b0;
          st_we        = 1'b1;
          st_waddr     = '0;
          st_wdata     = key_in;
        end
      end
      LOAD: begin
        busy    = 1'b1;
        state_d = EXPAND;
        round_d = 4'd1;
        cnt_d   = '0;
      end
      EXPAND: begin
        busy = 1'b1;
        if (cnt_q == CNT_END) begin
          cnt_d   = '0;
          state_d = CAPT;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      CAPT: begin
        busy  = 1'b1;
        st_we = 1'b1;
        // Round stays at NR in DONE; it never wraps.
        if (round_q >= ROUND_LAST) begin
          state_d      = DONE;
          keys_valid_d = 1'b1;
        end else begin
          round_d = round_q + 4'd1;
          state_d = EXPAND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  round_key_store #(
    .DEPTH (KEY_STORE_DEPTH),
    .KW    (KW)
  ) u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (st_we),
    .wr_addr_i (st_waddr),
    .wr_data_i (st_wdata),
    .rd_addr_i (rk_rd_addr),
    .rd_data_o (rk_rd_data)
  );

  assign ke_key_o   = key_q;
  assign ke_round_o = round_q;
  assign ke_cnt_o   = cnt_q;
  assign keys_valid = keys_valid_q;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Bench for key_schedule_ctrl with a behavioural AES-128 key-expansion stage.
module tb_key_schedule_ctrl;

  localparam int unsigned KW = 128;
  localparam logic [KW-1:0] FIPS_KEY  = 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516;
  localparam logic [KW-1:0] FIPS_RK10 = 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  key_schedule_ctrl_if #(.KW(KW)) bus ();

  logic [KW-1:0] ke_key;
  logic [KW-1:0] ke_rk;
  logic [3:0]    ke_round;
  logic [2:0]    ke_cnt;

  key_schedule_ctrl #(.NR(10), .KW(KW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .key_valid      (bus.key_valid),
    .key_in         (bus.key_in),
    .key_ready      (bus.key_ready),
    .ke_key_o       (ke_key),
    .ke_round_o     (ke_round),
    .ke_cnt_o       (ke_cnt),
    .ke_round_key_i (ke_rk),
    .rk_rd_addr     (bus.rk_rd_addr),
    .rk_rd_data     (bus.rk_rd_data),
    .keys_valid     (bus.keys_valid),
    .busy           (bus.busy)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] sbox_t [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Round key r of the FIPS-197 schedule; word w0 lives in bits [31:0].
  function automatic logic [KW-1:0] round_key(input logic [KW-1:0] key, input int unsigned r);
    logic [31:0] w [4];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    rc = 8'h01;
    for (int unsigned k = 1; k <= r && k <= 10; k++) begin
      t = {w[3][23:0], w[3][31:24]};
      t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
      w[0] ^= t;
      w[1] ^= w[0];
      w[2] ^= w[1];
      w[3] ^= w[2];
      rc = xt(rc);
    end
    return {w[3], w[2], w[1], w[0]};
  endfunction

  function automatic logic [KW-1:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Registered key-expansion stage driven by the controller.
  always_ff @(posedge clk) ke_rk <= round_key(ke_key, int'(ke_round));

  // Handshake, then check every cycle of the 91-cycle expansion against the schedule.
  task automatic run_keys(input logic [KW-1:0] key, input int pulse_at, input int abort_at,
                          output logic kv0, output logic [KW-1:0] rd0, output logic [KW-1:0] rd1);
    int bad;
    int er;
    int ec;
    bad = 0;
    kv0 = 1'bx;
    rd0 = 'x;
    rd1 = 'x;
    @(negedge clk);
    tests++;
    if (bus.key_ready !== 1'b1) begin
      fails++;
      $display("FAIL handshake_ready: key_ready=%b required 1", bus.key_ready);
    end
    bus.key_valid = 1'b1;
    bus.key_in    = key;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    bus.key_in    = rand_key();
    for (int c = 0; c <= 90; c++) begin
      @(negedge clk);
      if (c == abort_at) return;
      if (c == 0) begin
        kv0 = bus.keys_valid;
        rd0 = bus.rk_rd_data;
      end
      if (c == 1) rd1 = bus.rk_rd_data;
      er = (c == 0) ? 0 : (c - 1) / 9 + 1;
      ec = (c == 0) ? 0 : ((((c - 1) % 9) < 8) ? (c - 1) % 9 : 0);
      if (ke_round !== 4'(er) || ke_cnt !== 3'(ec) || bus.busy !== 1'b1 ||
          bus.key_ready !== 1'b0 || bus.keys_valid !== 1'b0 || ke_key !== key) begin
        if (bad == 0)
          $display("FAIL trace c=%0d: round=%0d cnt=%0d busy=%b ready=%b kv=%b key=%h, required round=%0d cnt=%0d busy=1 ready=0 kv=0 key=%h",
                   c, ke_round, ke_cnt, bus.busy, bus.key_ready, bus.keys_valid, ke_key, er, ec, key);
        bad++;
      end
      bus.key_valid = (c == pulse_at);
      bus.key_in    = rand_key();
    end
    tests++;
    if (bad != 0) fails++;
    @(negedge clk);
    bus.key_valid = 1'b0;
    tests++;
    if (bus.keys_valid !== 1'b1 || bus.busy !== 1'b0 || bus.key_ready !== 1'b1 || ke_round !== 4'd10) begin
      fails++;
      $display("FAIL latency91: kv=%b busy=%b ready=%b round=%0d, required kv=1 busy=0 ready=1 round=10",
               bus.keys_valid, bus.busy, bus.key_ready, ke_round);
    end
  endtask

  task automatic test_store_contents(input logic [KW-1:0] key);
    int unsigned off;
    int unsigned a;
    logic [KW-1:0] exp;
    off = $urandom_range(0, 15);
    for (int unsigned i = 0; i < 16; i++) begin
      a = (i + off) % 16;
      @(negedge clk);
      bus.rk_rd_addr = 4'(a);
      @(negedge clk);
      exp = (a <= 10) ? round_key(key, a) : '0;
      tests++;
      if (bus.rk_rd_data !== exp) begin
        fails++;
        $display("FAIL store[%0d]: got %h required %h", a, bus.rk_rd_data, exp);
      end
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.key_valid  = 1'b0;
    bus.key_in     = '0;
    bus.rk_rd_addr = '0;
    repeat (2) @(negedge clk);
    tests++;
    if (bus.keys_valid !== 1'b0 || bus.busy !== 1'b0 || bus.key_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_flags: kv=%b busy=%b ready=%b required 0 0 1", bus.keys_valid, bus.busy, bus.key_ready);
    end
    tests++;
    if (ke_round !== 4'd0 || ke_cnt !== 3'd0 || ke_key !== '0 || bus.rk_rd_data !== '0) begin
      fails++;
      $display("FAIL reset_regs: round=%0d cnt=%0d key=%h rd=%h required all zero", ke_round, ke_cnt, ke_key, bus.rk_rd_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fips();
    logic kv0;
    logic [KW-1:0] rd0, rd1;
    run_keys(FIPS_KEY, -1, -1, kv0, rd0, rd1);
    @(negedge clk);
    bus.rk_rd_addr = 4'd10;
    @(negedge clk);
    tests++;
    if (bus.rk_rd_data !== FIPS_RK10) begin
      fails++;
      $display("FAIL fips_rk10: got %h required %h", bus.rk_rd_data, FIPS_RK10);
    end
    bus.rk_rd_addr = 4'd0;
    @(negedge clk);
    tests++;
    if (bus.rk_rd_data !== FIPS_KEY) begin
      fails++;
      $display("FAIL fips_rk0: got %h required %h", bus.rk_rd_data, FIPS_KEY);
    end
    bus.rk_rd_addr = 4'd12;
    @(negedge clk);
    tests++;
    if (bus.rk_rd_data !== '0) begin
      fails++;
      $display("FAIL read_oob12: got %h required 0", bus.rk_rd_data);
    end
    bus.rk_rd_addr = 4'd5;
    #1;
    tests++;
    if (bus.rk_rd_data !== '0) begin
      fails++;
      $display("FAIL read_latency: got %h before the edge, required 0", bus.rk_rd_data);
    end
    @(negedge clk);
    tests++;
    if (bus.rk_rd_data !== round_key(FIPS_KEY, 5)) begin
      fails++;
      $display("FAIL read_rk5: got %h required %h", bus.rk_rd_data, round_key(FIPS_KEY, 5));
    end
    test_store_contents(FIPS_KEY);
  endtask

  task automatic test_busy_pulse();
    logic kv0;
    logic [KW-1:0] rd0, rd1;
    run_keys(FIPS_KEY, 40, -1, kv0, rd0, rd1);
    @(negedge clk);
    bus.rk_rd_addr = 4'd10;
    @(negedge clk);
    tests++;
    if (bus.rk_rd_data !== FIPS_RK10) begin
      fails++;
      $display("FAIL pulse_rk10: got %h required %h", bus.rk_rd_data, FIPS_RK10);
    end
    bus.rk_rd_addr = 4'd0;
    @(negedge clk);
    tests++;
    if (bus.rk_rd_data !== FIPS_KEY) begin
      fails++;
      $display("FAIL pulse_rk0: got %h required %h", bus.rk_rd_data, FIPS_KEY);
    end
  endtask

  task automatic test_reset_mid();
    logic kv0;
    logic [KW-1:0] rd0, rd1, k1, k2;
    k1 = rand_key();
    k2 = rand_key();
    run_keys(k1, -1, 50, kv0, rd0, rd1);
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.keys_valid !== 1'b0 || bus.busy !== 1'b0 || bus.key_ready !== 1'b1) begin
      fails++;
      $display("FAIL midreset_flags: kv=%b busy=%b ready=%b required 0 0 1", bus.keys_valid, bus.busy, bus.key_ready);
    end
    tests++;
    if (ke_round !== 4'd0 || ke_cnt !== 3'd0 || ke_key !== '0 || bus.rk_rd_data !== '0) begin
      fails++;
      $display("FAIL midreset_regs: round=%0d cnt=%0d key=%h rd=%h required all zero", ke_round, ke_cnt, ke_key, bus.rk_rd_data);
    end
    @(negedge clk);
    tests++;
    if (bus.keys_valid !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL midreset_hold: kv=%b busy=%b required 0 0", bus.keys_valid, bus.busy);
    end
    rst_n = 1'b1;
    run_keys(k2, -1, -1, kv0, rd0, rd1);
    test_store_contents(k2);
  endtask

  task automatic test_back_to_back();
    logic kv0;
    logic [KW-1:0] rd0, rd1, k1, k2;
    k1 = rand_key();
    k2 = rand_key();
    run_keys(k1, -1, -1, kv0, rd0, rd1);
    bus.rk_rd_addr = 4'd0;
    run_keys(k2, -1, -1, kv0, rd0, rd1);
    tests++;
    if (kv0 !== 1'b0) begin
      fails++;
      $display("FAIL b2b_kv_drop: keys_valid=%b one cycle after handshake, required 0", kv0);
    end
    tests++;
    if (rd0 !== k1) begin
      fails++;
      $display("FAIL b2b_read_old: got %h required %h", rd0, k1);
    end
    tests++;
    if (rd1 !== k2) begin
      fails++;
      $display("FAIL b2b_read_new: got %h required %h", rd1, k2);
    end
    test_store_contents(k2);
    tests++;
    if (ke_round !== 4'd10 || ke_cnt !== 3'd0 || bus.keys_valid !== 1'b1 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL done_hold: round=%0d cnt=%0d kv=%b busy=%b required 10 0 1 0", ke_round, ke_cnt, bus.keys_valid, bus.busy);
    end
  endtask

  task automatic test_random_keys();
    logic kv0;
    logic [KW-1:0] rd0, rd1, k;
    for (int n = 0; n < 3; n++) begin
      k = rand_key();
      run_keys(k, int'($urandom_range(1, 90)), -1, kv0, rd0, rd1);
      test_store_contents(k);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
    test_reset();
    test_fips();
    test_busy_pulse();
    test_reset_mid();
    test_back_to_back();
    test_random_keys();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
